// File: rtl/udma_cfg_apb_bridge.sv
// APB slave to uDMA cfg-bus initiator.
// Writes are posted through a small FIFO so the CPU does not stall.
// Reads wait until every posted write has drained, then issue one cfg read.
// Every cfg transaction is bounded by a timeout. A write that times out is
// dropped and sets a sticky error flag. The next read reports that flag
// through pslverr and then clears it.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no cfg request; start a write (FIFO has data) or a read
// S_WR   | FIFO head on the cfg bus as a write, waiting for ready/timeout
// S_RD   | APB read address on the cfg bus as a read, waiting ready/timeout
// S_RESP | read data (or timeout error) returned to the APB master
module udma_cfg_apb_bridge #(
   parameter int APB_AWIDTH = 12,
   parameter int WBUF_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [APB_AWIDTH-1:0] apb_paddr_i,
   input  logic [31:0]           apb_pwdata_i,
   input  logic                  apb_pwrite_i,
   input  logic                  apb_psel_i,
   input  logic                  apb_penable_i,
   output logic [31:0]           apb_prdata_o,
   output logic                  apb_pready_o,
   output logic                  apb_pslverr_o,
   output logic [4:0]            cfg_addr_o,
   output logic [31:0]           cfg_data_o,
   output logic                  cfg_valid_o,
   output logic                  cfg_rwn_o,
   input  logic [31:0]           cfg_data_i,
   input  logic                  cfg_ready_i,
   output logic                  busy_o
);

   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(WBUF_DEPTH);
   localparam logic [7:0]    C_TMO   = 8'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RESP} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [36:0]     r_mem [WBUF_DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [7:0]      r_tmr;
   logic            r_err;
   logic            r_rd_to;
   logic [31:0]     r_rdata;
   logic [4:0]      r_rd_addr;

   logic            w_access;
   logic            w_oor;
   logic            w_wr_acc;
   logic            w_rd_acc;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_wait_done;
   logic [36:0]     w_head;
   logic            w_unused;

   // The async reset also gates the APB side, so every output reads 0 during reset.
   assign w_access    = ~rst_i & apb_psel_i & apb_penable_i;
   assign w_oor       = |apb_paddr_i[APB_AWIDTH-1:7];
   assign w_wr_acc    = w_access & ~w_oor & apb_pwrite_i;
   assign w_rd_acc    = w_access & ~w_oor & ~apb_pwrite_i;
   assign w_full      = (r_count == C_DEPTH);
   assign w_empty     = (r_count == '0);
   // Full is judged on the registered count, so a same-cycle pop cannot admit a push.
   assign w_push      = w_wr_acc & ~w_full;
   assign w_wait_done = cfg_ready_i | (r_tmr == 8'd0);
   // A timed-out write is still popped, which drops it from the FIFO.
   assign w_pop       = (r_state == S_WR) & w_wait_done;
   assign w_head      = r_mem[r_rd_ptr];
   assign busy_o      = ~w_empty | (r_state != S_IDLE);
   assign w_unused    = ^apb_paddr_i[1:0];

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state, cfg request and APB response
   always_comb begin
      w_state_nxt   = r_state;
      cfg_valid_o   = 1'b0;
      cfg_rwn_o     = 1'b0;
      cfg_addr_o    = 5'd0;
      cfg_data_o    = 32'd0;
      apb_pready_o  = 1'b0;
      apb_pslverr_o = 1'b0;
      apb_prdata_o  = 32'd0;
      case (r_state)
         S_IDLE: begin
            // A push in this cycle is enough to start the write next cycle.
            if (!w_empty || w_push) w_state_nxt = S_WR;
            else if (w_rd_acc)      w_state_nxt = S_RD;
         end
         S_WR: begin
            cfg_valid_o = 1'b1;
            cfg_addr_o  = w_head[36:32];
            cfg_data_o  = w_head[31:0];
            if (w_wait_done) w_state_nxt = S_IDLE;
         end
         S_RD: begin
            cfg_valid_o = 1'b1;
            cfg_rwn_o   = 1'b1;
            cfg_addr_o  = r_rd_addr;
            if (w_wait_done) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_access && w_oor) begin
         apb_pready_o  = 1'b1;
         apb_pslverr_o = 1'b1;
      end else if (w_wr_acc) begin
         apb_pready_o  = ~w_full;
      end else if (w_rd_acc && (r_state == S_RESP)) begin
         apb_pready_o  = 1'b1;
         apb_prdata_o  = r_rdata;
         apb_pslverr_o = r_err | r_rd_to;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents beyond the count are don't-care, so no reset
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= {apb_paddr_i[6:2], apb_pwdata_i};
   end

   // Timeout down-counter: preloaded while idle, expires when it reaches zero
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                   r_tmr <= C_TMO;
      else if (r_state == S_IDLE)  r_tmr <= C_TMO;
      else if ((r_state == S_WR || r_state == S_RD) && !cfg_ready_i && r_tmr != 8'd0)
                                   r_tmr <= r_tmr - 8'd1;
   end

   // Read address capture, read data capture and the sticky write-error flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rd_addr <= 5'd0;
         r_rdata   <= 32'd0;
         r_rd_to   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_state_nxt == S_RD) r_rd_addr <= apb_paddr_i[6:2];
         if (r_state == S_RD) begin
            if (cfg_ready_i) begin
               r_rdata <= cfg_data_i;
               r_rd_to <= 1'b0;
            end else if (r_tmr == 8'd0) begin
               r_rdata <= 32'd0;
               r_rd_to <= 1'b1;
            end
         end
         if (r_state == S_WR && !cfg_ready_i && r_tmr == 8'd0) r_err <= 1'b1;
         else if (r_state == S_RESP && w_rd_acc)                r_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_udma_cfg_apb_bridge.sv
// Bench for udma_cfg_apb_bridge: directed steps, then a random APB mix.
// The reference is a word memory plus an in-order list of expected cfg
// transactions. A small cfg target answers reads from its own memory.
module tb_udma_cfg_apb_bridge;
   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic        pwrite = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic [4:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic        cfg_valid;
   logic        cfg_rwn;
   logic [31:0] cfg_rdata;
   logic        cfg_ready = 1'b0;
   logic        busy;

   always #5 clk = ~clk;

   udma_cfg_apb_bridge #(.APB_AWIDTH(12), .WBUF_DEPTH(4), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst),
      .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_pwrite_i(pwrite),
      .apb_psel_i(psel), .apb_penable_i(penable),
      .apb_prdata_o(prdata), .apb_pready_o(pready), .apb_pslverr_o(pslverr),
      .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_wdata), .cfg_valid_o(cfg_valid),
      .cfg_rwn_o(cfg_rwn), .cfg_data_i(cfg_rdata), .cfg_ready_i(cfg_ready),
      .busy_o(busy)
   );

   int total = 0;
   int bad = 0;

   logic [31:0] ref_mem [32];
   logic [31:0] tgt_mem [32];
   logic        ref_err = 1'b0;
   logic [37:0] exp_q [$];
   logic [37:0] obs_q [$];
   int          pop_q [$];
   int          cyc = 0;
   int          hold_err = 0, drop_err = 0, dz_err = 0, vtot = 0, vrun = 0, last_run = 0;
   logic        pv = 1'b0, pr = 1'b0, mem_init = 1'b0;
   logic [37:0] preq = '0;
   int          rdy_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random
   int          acc_cyc = 0;

   function automatic logic [31:0] preload(input int i);
      return (i == 2) ? 32'h0000_1234 : 32'hC0DE_0000 + 32'(i) * 32'h111;
   endfunction

   assign cfg_rdata = tgt_mem[cfg_addr];

   always @(posedge clk) begin
      #2;
      cfg_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
   end

   // cfg target and bus monitor
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!mem_init) begin
         for (int i = 0; i < 32; i++) tgt_mem[i] <= preload(i);
         mem_init <= 1'b1;
      end
      if (rst) begin
         vrun <= 0;
         pv   <= 1'b0;
         pr   <= 1'b0;
      end else begin
         if (cfg_valid && cfg_ready) begin
            obs_q.push_back({cfg_rwn, cfg_addr, cfg_wdata});
            pop_q.push_back(cyc);
            if (!cfg_rwn) tgt_mem[cfg_addr] <= cfg_wdata;
         end
         if (pv && !pr && cfg_valid && ({cfg_rwn, cfg_addr, cfg_wdata} != preq)) hold_err <= hold_err + 1;
         if (pv && !pr && !cfg_valid && vrun != TMO + 1) drop_err <= drop_err + 1;
         if ((!cfg_valid || cfg_rwn) && cfg_wdata != 32'd0) dz_err <= dz_err + 1;
         if (cfg_valid) vtot <= vtot + 1;
         if (cfg_valid) vrun <= vrun + 1;
         else begin
            if (vrun > 0) last_run <= vrun;
            vrun <= 0;
         end
         pv   <= cfg_valid;
         pr   <= cfg_ready;
         preq <= {cfg_rwn, cfg_addr, cfg_wdata};
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic err, output int waits);
      @(negedge clk);
      psel = 1'b1; pwrite = wr; paddr = a; pwdata = d; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      #1;
      waits = 0;
      while (!pready && waits < 600) begin
         @(negedge clk);
         #1;
         waits++;
      end
      chk(wr ? "wr_pready" : "rd_pready", 64'(pready), 64'd1);
      rd  = prdata;
      err = pslverr;
      @(posedge clk);
      #1;
      acc_cyc = cyc - 1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic do_wr(input logic [11:0] a, input logic [31:0] d, output int waits);
      logic [31:0] rd;
      logic        err;
      apb_xfer(1'b1, a, d, rd, err, waits);
      chk("wr_err", 64'(err), 64'd0);
      ref_mem[a[6:2]] = d;
      exp_q.push_back({1'b0, a[6:2], d});
   endtask

   task automatic do_rd(input logic [11:0] a, input string tag, output int waits);
      logic [31:0] rd;
      logic        err;
      apb_xfer(1'b0, a, 32'd0, rd, err, waits);
      chk({tag, "_data"}, 64'(rd), 64'(ref_mem[a[6:2]]));
      chk({tag, "_err"}, 64'(err), 64'(ref_err));
      ref_err = 1'b0;
      exp_q.push_back({1'b1, a[6:2], 32'd0});
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(tag, 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic cmp_q(input string tag);
      chk({tag, "_cnt"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk($sformatf("%s_%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;
      int          w, w5, v0, pop0;
      logic [11:0] a;
      logic [31:0] d;

      for (int i = 0; i < 32; i++) ref_mem[i] = preload(i);

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_outs", 64'({pready, pslverr, prdata, cfg_valid, cfg_rwn, cfg_addr, cfg_wdata, busy}), 64'd0);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h080;
      #1;
      chk("rst_apb_gated", 64'({pready, pslverr, prdata}), 64'd0);
      psel = 1'b0; penable = 1'b0; paddr = '0;
      @(negedge clk);
      rst = 1'b0;
      obs_q.delete();
      pop_q.delete();

      // single posted write, request visible the cycle after the access
      apb_xfer(1'b1, 12'h004, 32'hAABB_CCDD, rd, err, w);
      chk("t1_waits", 64'(w), 64'd0);
      chk("t1_req", 64'({cfg_valid, cfg_rwn, cfg_addr, cfg_wdata}), 64'({1'b1, 1'b0, 5'd1, 32'hAABB_CCDD}));
      ref_mem[1] = 32'hAABB_CCDD;
      exp_q.push_back({1'b0, 5'd1, 32'hAABB_CCDD});
      wait_idle("t1_idle");
      cmp_q("t1_q");

      // read from an empty FIFO with ready tied high: two wait states
      do_rd(12'h004, "lat", w);
      chk("lat_waits", 64'(w), 64'd2);
      wait_idle("lat_idle");
      cmp_q("lat_q");

      // FIFO fill and full stall
      rdy_mode = 0;
      for (int i = 0; i < 4; i++) begin
         do_wr(12'((i + 8) * 4), $urandom, w);
         chk($sformatf("t2_waits_%0d", i), 64'(w), 64'd0);
      end
      pop_q.delete();
      d = $urandom;
      fork
         do_wr(12'h030, d, w5);
         begin
            repeat (6) @(negedge clk);
            rdy_mode = 1;
         end
      join
      chk("t2_w5_stalled", 64'(w5 > 0), 64'd1);
      pop0 = (pop_q.size() > 0) ? pop_q[0] : -100;
      chk("t2_acc_after_pop", 64'(acc_cyc), 64'(pop0 + 1));
      wait_idle("t2_idle");
      cmp_q("t2_q");

      // posted writes are ordered ahead of a read
      rdy_mode = 2;
      do_wr(12'h014, $urandom, w);
      do_wr(12'h018, $urandom, w);
      do_wr(12'h01C, $urandom, w);
      do_rd(12'h008, "t3", w);
      wait_idle("t3_idle");
      cmp_q("t3_q");

      // read timeout
      rdy_mode = 0;
      @(negedge clk);
      apb_xfer(1'b0, 12'h00C, 32'd0, rd, err, w);
      chk("t4_rd_data", 64'(rd), 64'd0);
      chk("t4_rd_err", 64'(err), 64'd1);
      chk("t4_rd_len", 64'(last_run), 64'(TMO + 1));
      chk("t4_rd_waits", 64'(w), 64'(TMO + 2));
      // write timeout: entry dropped, sticky error on the next read only
      last_run = 0;
      apb_xfer(1'b1, 12'h010, 32'hBAD0_BAD0, rd, err, w);
      chk("t4_wr_waits", 64'(w), 64'd0);
      wait_idle("t4_wr_idle");
      chk("t4_wr_len", 64'(last_run), 64'(TMO + 1));
      cmp_q("t4_q0");
      rdy_mode = 1;
      ref_err = 1'b1;
      do_rd(12'h010, "t4_err_rd", w);
      do_rd(12'h010, "t4_clr_rd", w);
      wait_idle("t4_idle");
      cmp_q("t4_q1");

      // out-of-range accesses
      v0 = vtot;
      apb_xfer(1'b1, 12'h080, 32'h1111_2222, rd, err, w);
      chk("t5_wr", 64'({w[7:0], err}), 64'({8'd0, 1'b1}));
      apb_xfer(1'b0, 12'h080, 32'd0, rd, err, w);
      chk("t5_rd", 64'({w[7:0], err, rd}), 64'({8'd0, 1'b1, 32'd0}));
      repeat (5) @(negedge clk);
      chk("t5_no_cfg", 64'(vtot - v0), 64'd0);
      cmp_q("t5_q");

      // reset in the middle of a transaction
      rdy_mode = 0;
      apb_xfer(1'b1, 12'h020, 32'h5555_0001, rd, err, w);
      apb_xfer(1'b1, 12'h024, 32'h5555_0002, rd, err, w);
      chk("t6_pre", 64'({cfg_valid, busy}), 64'({1'b1, 1'b1}));
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_async", 64'({cfg_valid, busy, cfg_wdata, cfg_addr}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rdy_mode = 1;
      obs_q.delete();
      v0 = vtot;
      repeat (20) @(negedge clk);
      #1;
      chk("t6_no_stale", 64'(vtot - v0), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      cmp_q("t6_q");

      // random mix
      rdy_mode = 2;
      for (int n = 0; n < 80; n++) begin
         int r;
         r = $urandom_range(0, 9);
         a = {5'd0, 5'($urandom_range(0, 31)), 2'b00};
         if (r < 6) do_wr(a, $urandom, w);
         else if (r < 9) do_rd(a, "rnd", w);
         else begin
            apb_xfer(r[0], a | 12'h080, $urandom, rd, err, w);
            chk("rnd_oor", 64'({w[7:0], err, rd}), 64'({8'd0, 1'b1, 32'd0}));
         end
      end
      wait_idle("rnd_idle");
      cmp_q("rnd_q");

      chk("hold_err", 64'(hold_err), 64'd0);
      chk("drop_err", 64'(drop_err), 64'd0);
      chk("data_zero_err", 64'(dz_err), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
